// File: rtl/mul16_seq.sv
// rtl/mul16_seq.sv - sequential shift-and-add 16x16 multiplier on one shared 16-bit adder

module add16 (
    input  logic [15:0] x,
    input  logic [15:0] y,
    output logic [15:0] s
);
    assign s = x + y;
endmodule

module mul16_seq #(
    parameter int WIDTH      = 16,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] out,
    output logic             ovf
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mcand, mplier, acc, sum, acc_nxt;
    logic [3:0]       cnt;
    logic             lost, carry, last, accept;

    add16 u_add (.x(acc), .y(mcand), .s(sum));

    // The adder has no carry-out; a wrapped sum is always smaller than its addend.
    assign carry   = (sum < acc);
    assign acc_nxt = mplier[0] ? sum : acc;
    assign last    = (cnt == 4'(WIDTH - 1)) ||
                     (EARLY_EXIT && (mplier[WIDTH-1:1] == '0));
    assign accept  = (state != S_RUN) && start;

    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_RUN;
            end
            S_RUN: begin
                busy = 1'b1;
                if (last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
            lost   <= 1'b0;
            out    <= '0;
            ovf    <= 1'b0;
        end else if (accept) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            lost   <= 1'b0;
            ovf    <= 1'b0;
        end else if (state == S_RUN) begin
            acc <= acc_nxt;
            // lost means the current mcand already dropped a bit beyond 2^16
            if (mplier[0] && (carry || lost)) ovf <= 1'b1;
            lost   <= lost | mcand[WIDTH-1];
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 4'd1;
            if (last) out <= acc_nxt;
        end
    end
endmodule

// File: tb/tb_mul16_seq.sv
// tb/tb_mul16_seq.sv - self-checking bench for mul16_seq (early-exit and full-length instances)

module tb_mul16_seq;
    logic        clk = 1'b0;
    logic        reset;
    logic        start, start0;
    logic [15:0] a, b, a0, b0;
    logic        busy, done, ovf, busy0, done0, ovf0;
    logic [15:0] out, out0;

    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    mul16_seq #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start), .a(a), .b(b),
        .busy(busy), .done(done), .out(out), .ovf(ovf)
    );

    mul16_seq #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut0 (
        .clk(clk), .reset(reset), .start(start0), .a(a0), .b(b0),
        .busy(busy0), .done(done0), .out(out0), .ovf(ovf0)
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] out;
        logic        ovf;
        int          n;
    } vec_t;

    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void model(input logic [15:0] x, input logic [15:0] y, input bit ee,
                                  output logic [15:0] o, output logic v, output int n);
        logic [31:0] p;
        p = {16'd0, x} * {16'd0, y};
        o = p[15:0];
        v = (p >= 32'd65536);
        n = 1;
        if (!ee) n = 16;
        else for (int i = 0; i < 16; i++) if (y[i]) n = i + 1;
    endfunction

    task automatic launch(input bit sel, input logic [15:0] x, input logic [15:0] y);
        if (sel) begin start0 = 1'b1; a0 = x; b0 = y; end
        else     begin start  = 1'b1; a  = x; b  = y; end
        @(posedge clk); #1;
        start  = 1'b0;
        start0 = 1'b0;
    endtask

    // Entered #1 after an edge in RUN cycle cyc0; returns inside the done cycle.
    task automatic wait_done(input bit sel, input logic [15:0] eo, input logic eovf,
                             input int n, input int cyc0, input string name);
        int cyc = cyc0;
        bit busy_ok = 1'b1;
        while (!(sel ? done0 : done) && cyc < 40) begin
            if (!(sel ? busy0 : busy)) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({name, " busy"},  32'(busy_ok), 32'd1);
        chk({name, " cycle"}, cyc, n + 1);
        chk({name, " out"},   sel ? out0 : out, eo);
        chk({name, " ovf"},   sel ? ovf0 : ovf, eovf);
    endtask

    task automatic finish_op(input bit sel, input logic [15:0] eo, input string name);
        @(posedge clk); #1;
        chk({name, " done pulse"}, sel ? done0 : done, 1'b0);
        chk({name, " idle"},       sel ? busy0 : busy, 1'b0);
        chk({name, " held"},       sel ? out0 : out, eo);
    endtask

    task automatic run_rand(input bit sel, input logic [15:0] x, input logic [15:0] y);
        logic [15:0] eo;
        logic        ev;
        int          n;
        model(x, y, !sel, eo, ev, n);
        launch(sel, x, y);
        wait_done(sel, eo, ev, n, 1, "rand");
        finish_op(sel, eo, "rand");
    endtask

    initial begin
        logic [15:0] eo, x, y;
        logic        ev;
        int          n, dcount;

        tbl[0] = '{16'h0003, 16'h0005, 16'h000F, 1'b0, 3};
        tbl[1] = '{16'h0100, 16'h0010, 16'h1000, 1'b0, 5};
        tbl[2] = '{16'h0100, 16'h0100, 16'h0000, 1'b1, 9};
        tbl[3] = '{16'hFFFF, 16'h0002, 16'hFFFE, 1'b1, 2};
        tbl[4] = '{16'h8000, 16'h0001, 16'h8000, 1'b0, 1};
        tbl[5] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1};
        tbl[6] = '{16'hFFFF, 16'h0000, 16'h0000, 1'b0, 1};
        tbl[7] = '{16'h0007, 16'h0009, 16'h003F, 1'b0, 4};

        reset = 1'b1; start = 1'b1; start0 = 1'b1;
        a = 16'h3; b = 16'h5; a0 = 16'h3; b0 = 16'h5;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset out",  out,  16'h0);
        chk("reset ovf",  ovf,  1'b0);
        chk("reset busy0", busy0, 1'b0);
        reset = 1'b0; start = 1'b0; start0 = 1'b0;
        @(posedge clk); #1;
        chk("post-reset busy", busy, 1'b0);

        for (int i = 0; i < 8; i++) begin
            launch(0, tbl[i].a, tbl[i].b);
            wait_done(0, tbl[i].out, tbl[i].ovf, tbl[i].n, 1, $sformatf("tbl%0d", i));
            finish_op(0, tbl[i].out, $sformatf("tbl%0d", i));
        end

        launch(1, 16'h0003, 16'h0005);
        wait_done(1, 16'h000F, 1'b0, 16, 1, "full 3x5");
        finish_op(1, 16'h000F, "full 3x5");

        launch(0, 16'h0007, 16'h0009);
        @(posedge clk); #1;
        start = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(0, 16'h003F, 1'b0, 4, 3, "ignore start");
        finish_op(0, 16'h003F, "ignore start");

        launch(0, 16'h0007, 16'h0009);
        repeat (2) begin @(posedge clk); #1; end
        chk("abort busy before", busy, 1'b1);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("abort busy", busy, 1'b0);
        chk("abort out",  out,  16'h0);
        dcount = 0;
        repeat (8) begin
            @(posedge clk); #1;
            if (done || busy) dcount++;
        end
        chk("abort no done", dcount, 0);

        launch(0, 16'h1234, 16'h0057);
        model(16'h1234, 16'h0057, 1'b1, eo, ev, n);
        wait_done(0, eo, ev, n, 1, "b2b first");
        launch(0, 16'hABCD, 16'h00F3);
        chk("b2b busy", busy, 1'b1);
        model(16'hABCD, 16'h00F3, 1'b1, eo, ev, n);
        wait_done(0, eo, ev, n, 1, "b2b second");
        finish_op(0, eo, "b2b second");

        for (int i = 0; i < 40; i++) begin
            x = 16'($urandom);
            y = 16'($urandom >> $urandom_range(0, 16));
            run_rand(0, x, y);
        end
        for (int i = 0; i < 6; i++) begin
            x = 16'($urandom);
            y = 16'($urandom >> $urandom_range(0, 16));
            run_rand(1, x, y);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
